// File: rtl/csr_periph_bundle.sv
// CSR-mapped peripheral bundle: 64-bit cycle/instret counters, software output pins
// and a relative-deadline timer, all served over the pipeline CSR bus with 1-cycle read latency.
module csr_periph_bundle #(
    parameter logic [11:0]           PINS_ADDR   = 12'hBC1,
    parameter int                    PINS_COUNT  = 1,
    parameter logic [PINS_COUNT-1:0] PINS_RESET  = '0,
    parameter logic [11:0]           TIMER_ADDR  = 12'hBC2,
    parameter int                    TIMER_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  retired,
    input  logic                  read,
    input  logic [2:0]            modify,
    input  logic [31:0]           wdata,
    input  logic [11:0]           addr,
    output logic [31:0]           rdata,
    output logic                  valid,
    output logic [PINS_COUNT-1:0] pins,
    output logic                  irq_timer
);

    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_TIME      = 12'hC01;
    localparam logic [11:0] ADDR_TIMEH     = 12'hC81;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_SET   = 3'd2;
    localparam logic [2:0] OP_CLEAR = 3'd3;

    localparam logic [TIMER_WIDTH-1:0] T_ONE = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

    logic [63:0]            cycle_cnt;
    logic [63:0]            instret_cnt;
    logic [TIMER_WIDTH-1:0] now;
    logic [TIMER_WIDTH-1:0] deadline;
    logic                   armed;

    logic [TIMER_WIDTH-1:0] remaining;
    logic [TIMER_WIDTH-1:0] overdue;
    logic [31:0]            pins_ext;
    logic [31:0]            timer_ext;
    logic [31:0]            csr_value;
    logic [31:0]            new_val;
    logic                   owned;
    logic                   wr_en;

    logic wr_mcycle_lo;
    logic wr_mcycle_hi;
    logic wr_minstret_lo;
    logic wr_minstret_hi;
    logic wr_pins;
    logic wr_timer;

    // Comparing against now-1 gives the documented k+2 cycle irq latency for a write of k.
    always_comb begin
        remaining = deadline - now;
        overdue   = now - deadline - T_ONE;
    end

    always_comb begin
        pins_ext                   = '0;
        pins_ext[PINS_COUNT-1:0]   = pins;
        timer_ext                  = '0;
        timer_ext[TIMER_WIDTH-1:0] = remaining;
    end

    always_comb begin
        csr_value = '0;
        owned     = 1'b0;
        case (addr)
            ADDR_MCYCLE, ADDR_CYCLE, ADDR_TIME: begin
                csr_value = cycle_cnt[31:0];
                owned     = 1'b1;
            end
            ADDR_MCYCLEH, ADDR_CYCLEH, ADDR_TIMEH: begin
                csr_value = cycle_cnt[63:32];
                owned     = 1'b1;
            end
            ADDR_MINSTRET, ADDR_INSTRET: begin
                csr_value = instret_cnt[31:0];
                owned     = 1'b1;
            end
            ADDR_MINSTRETH, ADDR_INSTRETH: begin
                csr_value = instret_cnt[63:32];
                owned     = 1'b1;
            end
            PINS_ADDR: begin
                csr_value = pins_ext;
                owned     = 1'b1;
            end
            TIMER_ADDR: begin
                csr_value = timer_ext;
                owned     = 1'b1;
            end
            default: begin
                csr_value = '0;
                owned     = 1'b0;
            end
        endcase
    end

    // Set/clear operate on the current visible value, so for the timer they act on remaining.
    always_comb begin
        new_val = wdata;
        wr_en   = 1'b0;
        case (modify)
            OP_WRITE: begin
                new_val = wdata;
                wr_en   = 1'b1;
            end
            OP_SET: begin
                new_val = csr_value | wdata;
                wr_en   = 1'b1;
            end
            OP_CLEAR: begin
                new_val = csr_value & ~wdata;
                wr_en   = 1'b1;
            end
            default: begin
                new_val = wdata;
                wr_en   = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_mcycle_lo   = wr_en && (addr == ADDR_MCYCLE);
        wr_mcycle_hi   = wr_en && (addr == ADDR_MCYCLEH);
        wr_minstret_lo = wr_en && (addr == ADDR_MINSTRET);
        wr_minstret_hi = wr_en && (addr == ADDR_MINSTRETH);
        wr_pins        = wr_en && (addr == PINS_ADDR);
        wr_timer       = wr_en && (addr == TIMER_ADDR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
            valid <= 1'b0;
        end else begin
            rdata <= (read && owned) ? csr_value : '0;
            valid <= read && owned;
        end
    end

    // A half-write replaces that half and skips this cycle's increment; no carry either way.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (wr_mcycle_lo) begin
                cycle_cnt[31:0] <= new_val;
            end else if (wr_mcycle_hi) begin
                cycle_cnt[63:32] <= new_val;
            end else begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end

            if (wr_minstret_lo) begin
                instret_cnt[31:0] <= new_val;
            end else if (wr_minstret_hi) begin
                instret_cnt[63:32] <= new_val;
            end else begin
                instret_cnt <= instret_cnt + {63'd0, retired};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pins <= PINS_RESET;
        end else if (wr_pins) begin
            pins <= new_val[PINS_COUNT-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            now       <= '0;
            deadline  <= '0;
            armed     <= 1'b0;
            irq_timer <= 1'b0;
        end else begin
            now       <= now + T_ONE;
            irq_timer <= armed && !overdue[TIMER_WIDTH-1];
            if (wr_timer) begin
                deadline <= now + new_val[TIMER_WIDTH-1:0];
                armed    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_csr_periph_bundle.sv
// Directed bench for csr_periph_bundle: inputs change and outputs are sampled on the
// falling edge; each task checks its own hand-computed expectations.
module tb_csr_periph_bundle;

    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_TIME      = 12'hC01;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_PINS      = 12'hBC1;
    localparam logic [11:0] A_TIMER     = 12'hBC2;
    localparam logic [11:0] A_UNOWNED   = 12'hBC0;

    logic        clk = 1'b0;
    logic        rst;
    logic        retired;
    logic        read;
    logic [2:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic [0:0]  pins;
    logic        irq_timer;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    csr_periph_bundle dut (
        .clk       (clk),
        .rst       (rst),
        .retired   (retired),
        .read      (read),
        .modify    (modify),
        .wdata     (wdata),
        .addr      (addr),
        .rdata     (rdata),
        .valid     (valid),
        .pins      (pins),
        .irq_timer (irq_timer)
    );

    task automatic drive(input logic rd, input logic [2:0] op, input logic [11:0] a,
                         input logic [31:0] d);
        read   = rd;
        modify = op;
        addr   = a;
        wdata  = d;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 3'd0, A_MCYCLE, 32'd0);
        repeat (3) step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++; if (irq_timer !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq_timer); end
        checks++; if (pins !== 1'b0) begin errors++; $display("FAIL reset_pins: got %b want 0", pins); end
        rst = 1'b0;
        drive(1'b1, 3'd0, A_MCYCLE, 32'd0);
        step();
        checks++; if (rdata !== 32'd0 || valid !== 1'b1) begin errors++; $display("FAIL read_mcycle0: got %h/%b want 0/1", rdata, valid); end
        drive(1'b1, 3'd0, A_CYCLE, 32'd0);
        step();
        checks++; if (rdata !== 32'd1 || valid !== 1'b1) begin errors++; $display("FAIL read_cycle1: got %h/%b want 1/1", rdata, valid); end
        drive(1'b1, 3'd0, A_TIME, 32'd0);
        step();
        checks++; if (rdata !== 32'd2) begin errors++; $display("FAIL read_time2: got %h want 2", rdata); end
        drive(1'b0, 3'd0, 12'h000, 32'd0);
        step();
    endtask

    task automatic test_mcycle_wrap();
        drive(1'b0, 3'd1, A_MCYCLE, 32'hFFFF_FFFF);
        step();
        drive(1'b0, 3'd1, A_MCYCLEH, 32'd0);
        step();
        drive(1'b0, 3'd0, 12'h000, 32'd0);
        step();
        drive(1'b1, 3'd0, A_MCYCLEH, 32'd0);
        step();
        checks++; if (rdata !== 32'd1 || valid !== 1'b1) begin errors++; $display("FAIL mcycleh_carry: got %h/%b want 1/1", rdata, valid); end
        drive(1'b1, 3'd0, A_MCYCLE, 32'd0);
        step();
        checks++; if (rdata !== 32'd1) begin errors++; $display("FAIL mcycle_low_after_wrap: got %h want 1", rdata); end
        drive(1'b1, 3'd0, A_CYCLEH, 32'd0);
        step();
        checks++; if (rdata !== 32'd1) begin errors++; $display("FAIL cycleh_alias: got %h want 1", rdata); end
        drive(1'b0, 3'd0, 12'h000, 32'd0);
        step();
    endtask

    task automatic test_instret();
        rst = 1'b1;
        retired = 1'b0;
        drive(1'b0, 3'd0, 12'h000, 32'd0);
        step();
        rst = 1'b0;
        retired = 1'b1;
        repeat (5) step();
        retired = 1'b0;
        drive(1'b1, 3'd0, A_MINSTRET, 32'd0);
        step();
        checks++; if (rdata !== 32'd5) begin errors++; $display("FAIL minstret_5: got %h want 5", rdata); end
        drive(1'b1, 3'd1, A_INSTRET, 32'd1234);
        step();
        checks++; if (rdata !== 32'd5 || valid !== 1'b1) begin errors++; $display("FAIL instret_ro_write: got %h/%b want 5/1", rdata, valid); end
        drive(1'b1, 3'd0, A_INSTRET, 32'd0);
        step();
        checks++; if (rdata !== 32'd5) begin errors++; $display("FAIL instret_unchanged: got %h want 5", rdata); end
        retired = 1'b1;
        drive(1'b0, 3'd1, A_MINSTRET, 32'd100);
        step();
        retired = 1'b0;
        drive(1'b1, 3'd2, A_MINSTRET, 32'd3);
        step();
        checks++; if (rdata !== 32'd100) begin errors++; $display("FAIL modify_wins: got %0d want 100", rdata); end
        drive(1'b1, 3'd3, A_MINSTRET, 32'd1);
        step();
        checks++; if (rdata !== 32'd103) begin errors++; $display("FAIL set_op: got %0d want 103", rdata); end
        drive(1'b1, 3'd5, A_MINSTRET, 32'hFFFF);
        step();
        checks++; if (rdata !== 32'd102) begin errors++; $display("FAIL clear_op: got %0d want 102", rdata); end
        drive(1'b1, 3'd0, A_MINSTRET, 32'd0);
        step();
        checks++; if (rdata !== 32'd102) begin errors++; $display("FAIL op5_noeffect: got %0d want 102", rdata); end
        drive(1'b0, 3'd1, A_MINSTRETH, 32'd7);
        step();
        drive(1'b1, 3'd0, A_MINSTRETH, 32'd0);
        step();
        checks++; if (rdata !== 32'd7) begin errors++; $display("FAIL minstreth_write: got %0d want 7", rdata); end
        drive(1'b1, 3'd0, A_MINSTRET, 32'd0);
        step();
        checks++; if (rdata !== 32'd102) begin errors++; $display("FAIL minstret_low_kept: got %0d want 102", rdata); end
        drive(1'b0, 3'd0, 12'h000, 32'd0);
        step();
    endtask

    task automatic test_pins();
        drive(1'b0, 3'd1, A_PINS, 32'd1);
        step();
        checks++; if (pins !== 1'b1) begin errors++; $display("FAIL pins_write: got %b want 1", pins); end
        drive(1'b0, 3'd3, A_PINS, 32'd1);
        step();
        checks++; if (pins !== 1'b0) begin errors++; $display("FAIL pins_clear: got %b want 0", pins); end
        drive(1'b0, 3'd2, A_PINS, 32'hFFFF_FFFF);
        step();
        checks++; if (pins !== 1'b1) begin errors++; $display("FAIL pins_set: got %b want 1", pins); end
        drive(1'b1, 3'd0, A_PINS, 32'd0);
        step();
        checks++; if (rdata !== 32'd1 || valid !== 1'b1) begin errors++; $display("FAIL pins_read: got %h/%b want 1/1", rdata, valid); end
        drive(1'b1, 3'd0, A_UNOWNED, 32'd0);
        step();
        checks++; if (rdata !== 32'd0 || valid !== 1'b0) begin errors++; $display("FAIL unowned_read: got %h/%b want 0/0", rdata, valid); end
        drive(1'b0, 3'd0, A_MCYCLE, 32'd0);
        step();
        checks++; if (rdata !== 32'd0 || valid !== 1'b0) begin errors++; $display("FAIL read_low: got %h/%b want 0/0", rdata, valid); end
    endtask

    task automatic test_timer();
        drive(1'b0, 3'd1, A_TIMER, 32'd10);
        for (int j = 1; j <= 12; j++) begin
            step();
            if (j == 5) begin
                checks++; if (rdata !== 32'd6 || valid !== 1'b1) begin errors++; $display("FAIL timer_remaining: got %0d/%b want 6/1", rdata, valid); end
            end
            checks++;
            if (irq_timer !== (j == 12)) begin
                errors++;
                $display("FAIL timer_irq_cycle%0d: got %b want %b", j, irq_timer, (j == 12));
            end
            if (j == 4) drive(1'b1, 3'd0, A_TIMER, 32'd0);
            else        drive(1'b0, 3'd0, 12'h000, 32'd0);
        end
        drive(1'b0, 3'd1, A_TIMER, 32'd100);
        step();
        drive(1'b0, 3'd0, 12'h000, 32'd0);
        checks++; if (irq_timer !== 1'b1) begin errors++; $display("FAIL rewrite_irq_hold: got %b want 1", irq_timer); end
        step();
        checks++; if (irq_timer !== 1'b0) begin errors++; $display("FAIL rewrite_irq_drop: got %b want 0", irq_timer); end
        drive(1'b0, 3'd1, A_TIMER, 32'd0);
        step();
        drive(1'b0, 3'd0, 12'h000, 32'd0);
        checks++; if (irq_timer !== 1'b0) begin errors++; $display("FAIL zero_irq_early: got %b want 0", irq_timer); end
        step();
        checks++; if (irq_timer !== 1'b1) begin errors++; $display("FAIL zero_irq_rise: got %b want 1", irq_timer); end
    endtask

    task automatic test_reset_abort();
        drive(1'b0, 3'd1, A_PINS, 32'd1);
        step();
        rst = 1'b1;
        drive(1'b1, 3'd0, A_MCYCLE, 32'd0);
        step();
        checks++; if (valid !== 1'b0 || rdata !== 32'd0) begin errors++; $display("FAIL reset_abort_read: got %h/%b want 0/0", rdata, valid); end
        checks++; if (irq_timer !== 1'b0) begin errors++; $display("FAIL reset_irq_clear: got %b want 0", irq_timer); end
        checks++; if (pins !== 1'b0) begin errors++; $display("FAIL reset_pins_clear: got %b want 0", pins); end
        rst = 1'b0;
        drive(1'b0, 3'd0, 12'h000, 32'd0);
        repeat (3) step();
        checks++; if (irq_timer !== 1'b0) begin errors++; $display("FAIL disarmed_after_reset: got %b want 0", irq_timer); end
    endtask

    initial begin
        rst = 1'b1;
        retired = 1'b0;
        drive(1'b0, 3'd0, 12'h000, 32'd0);
        test_reset();
        test_mcycle_wrap();
        test_instret();
        test_pins();
        test_timer();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
